// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value DATAWIDTH itself, hence the +1.
  function automatic int cnt_width(input int datawidth);
    return $clog2(datawidth + 1);
  endfunction

endpackage

// File: rtl/seq_div_mod_if.sv
// Start/done handshake and operand/result bundle of the sequential divider.
interface seq_div_mod_if #(
    parameter int DATAWIDTH = 64
);
    logic                 Start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic                 Busy;
    logic                 Done;
    logic [DATAWIDTH-1:0] q;
    logic [DATAWIDTH-1:0] r;
    logic                 DivByZero;

    modport master (output Start, a, b, input Busy, Done, q, r, DivByZero);
    modport slave  (input Start, a, b, output Busy, Done, q, r, DivByZero);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] rem,
    input  logic                 din,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic [DATAWIDTH-1:0] rem_next,
    output logic                 qbit
);
    // One extra bit so the shifted remainder can never overflow before the compare.
    logic [DATAWIDTH:0] shifted;
    logic [DATAWIDTH:0] diff;

    assign shifted  = {rem, din};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = (shifted >= {1'b0, divisor});
    assign rem_next = qbit ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
endmodule

// File: rtl/seq_div_mod.sv
// Multi-cycle unsigned divider (quotient + remainder), one restoring step per clock.
// Optional macro SEQ_DIV_EARLY_OUT_EN: skip the iteration when a < b.
module seq_div_mod
    import seq_div_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input logic          Clk,
    input logic          Rst,
    seq_div_mod_if.slave bus
);
    localparam int W  = DATAWIDTH;
    localparam int CW = cnt_width(DATAWIDTH);

    state_t        state;
    logic [W-1:0]  qreg;
    logic [W-1:0]  rem;
    logic [W-1:0]  divisor;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_next;
    logic          qbit;

    div_step #(.DATAWIDTH(W)) u_step (
        .rem      (rem),
        .din      (qreg[W-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // NOTE: all state, including the working registers, uses non-blocking
    // assignments and is cleared by reset so no stale operand survives it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            qreg          <= '0;
            rem           <= '0;
            divisor       <= '0;
            cnt           <= '0;
            bus.q         <= '0;
            bus.r         <= '0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.Done <= 1'b0;
                    state    <= IDLE;
                    if (bus.Start) begin
                        if (bus.b == '0) begin
                            bus.q         <= '1;
                            bus.r         <= bus.a;
                            bus.DivByZero <= 1'b1;
                            bus.Done      <= 1'b1;
                            state         <= DONE;
                        end
`ifdef SEQ_DIV_EARLY_OUT_EN
                        else if (bus.a < bus.b) begin
                            bus.q         <= '0;
                            bus.r         <= bus.a;
                            bus.DivByZero <= 1'b0;
                            bus.Done      <= 1'b1;
                            state         <= DONE;
                        end
`endif
                        else begin
                            qreg     <= bus.a;
                            rem      <= '0;
                            divisor  <= bus.b;
                            cnt      <= CW'(W);
                            bus.Busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Start is deliberately not looked at here.
                    qreg <= {qreg[W-2:0], qbit};
                    rem  <= rem_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bus.q         <= {qreg[W-2:0], qbit};
                        bus.r         <= rem_next;
                        bus.DivByZero <= 1'b0;
                        bus.Done      <= 1'b1;
                        bus.Busy      <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
